matmul_job_arbiter: RTL and testbench

//  Shares one matrix_multiply_10x10_pipelined engine among NUM_REQ requesters.

---
 rtl/matmul_job_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_matmul_job_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_job_arbiter.sv
// matmul_job_arbiter: round-robin sharing of one 10x10 matrix-multiply engine
// among NUM_REQ requesters. Latches the winner's operands, pulses the engine
// start, waits for the rising edge of the engine done level and returns C.
// Optional watchdog: define MATMUL_TIMEOUT_EN to abort jobs that never finish.
module matmul_job_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned MAT_W          = 800,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*MAT_W-1:0]   req_a,
  input  logic [NUM_REQ*MAT_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [MAT_W-1:0]           rsp_c,
  output logic                       rsp_err,
  output logic                       mm_start,
  output logic [MAT_W-1:0]           mm_a,
  output logic [MAT_W-1:0]           mm_b,
  input  logic [MAT_W-1:0]           mm_c,
  input  logic                       mm_done,
  output logic                       mm_reset,
  output logic                       busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_LAUNCH = 3'd2,
    S_BUSY   = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, winner_q;
  logic [PTR_W-1:0]   winner_c, rr_next_c, scan_idx;
  logic               found_c, done_q, evt_c, timeout_c;
  logic [NUM_REQ-1:0] req_ready_c, rsp_valid_q;
  logic [MAT_W-1:0]   mm_a_q, mm_b_q, rsp_c_q;
  logic               mm_start_q, busy_q;
  logic [MAT_W-1:0]   req_a_arr [NUM_REQ];
  logic [MAT_W-1:0]   req_b_arr [NUM_REQ];

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Unpack the per-requester operand buses
  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
    assign req_a_arr[g] = req_a[g*MAT_W +: MAT_W];
    assign req_b_arr[g] = req_b[g*MAT_W +: MAT_W];
  end

  // Round-robin search: first valid requester starting at rr_ptr
  always_comb begin
    winner_c = '0;
    found_c  = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
      if (!found_c && req_valid[scan_idx]) begin
        found_c  = 1'b1;
        winner_c = scan_idx;
      end
    end
    rr_next_c = (winner_c == PTR_W'(NUM_REQ - 1)) ? '0 : winner_c + PTR_W'(1);
  end

  // Only a rising edge of the done level counts; a stale high level is ignored
  assign evt_c = mm_done & ~done_q;

  // Ready is decoded from live req_valid so a request that drops is never taken
  assign req_ready_c = (state_q == S_GRANT && found_c) ? onehot(winner_c) : '0;

`ifdef MATMUL_TIMEOUT_EN
  logic [15:0] wdog_q;
  logic        rsp_err_q, mm_reset_q;
  assign timeout_c = (state_q == S_BUSY) && !evt_c && (wdog_q == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_c      = 1'b0;
`endif

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (|req_valid) state_d = S_GRANT;
      S_GRANT:  state_d = found_c ? S_LAUNCH : S_IDLE;
      S_LAUNCH: state_d = S_BUSY;
      S_BUSY:   if (evt_c || timeout_c) state_d = S_RESP;
      S_RESP:   if (rsp_ready[winner_q]) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM state, datapath latches and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      done_q      <= 1'b0;
      mm_a_q      <= '0;
      mm_b_q      <= '0;
      rsp_c_q     <= '0;
      rsp_valid_q <= '0;
      mm_start_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MATMUL_TIMEOUT_EN
      wdog_q      <= '0;
      rsp_err_q   <= 1'b0;
      mm_reset_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= mm_done;
      mm_start_q <= 1'b0;
`ifdef MATMUL_TIMEOUT_EN
      mm_reset_q <= 1'b0;
`endif
      case (state_q)
        S_GRANT: begin
          if (found_c) begin
            mm_a_q     <= req_a_arr[winner_c];
            mm_b_q     <= req_b_arr[winner_c];
            winner_q   <= winner_c;
            rr_ptr_q   <= rr_next_c;
            mm_start_q <= 1'b1;
          end
        end
        S_LAUNCH: begin
`ifdef MATMUL_TIMEOUT_EN
          wdog_q <= '0;
`endif
        end
        S_BUSY: begin
          if (evt_c) begin
            rsp_c_q     <= mm_c;
            rsp_valid_q <= onehot(winner_q);
          end
`ifdef MATMUL_TIMEOUT_EN
          else if (timeout_c) begin
            rsp_c_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= onehot(winner_q);
            mm_reset_q  <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready[winner_q]) begin
            rsp_valid_q <= '0;
`ifdef MATMUL_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = req_ready_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_c     = rsp_c_q;
  assign mm_start  = mm_start_q;
  assign mm_a      = mm_a_q;
  assign mm_b      = mm_b_q;
  assign busy      = busy_q;
`ifdef MATMUL_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
  assign mm_reset  = mm_reset_q;
`else
  assign rsp_err   = 1'b0;
  assign mm_reset  = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Directed bench for matmul_job_arbiter with a behavioural engine stub.
// The watchdog scenario is compiled only when MATMUL_TIMEOUT_EN is defined.
module tb_matmul_job_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned MAT_W   = 800;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*MAT_W-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]       req_ready, rsp_valid, rsp_ready;
  logic [MAT_W-1:0]         rsp_c, mm_a, mm_b, mm_c;
  logic                     rsp_err, mm_start, mm_done, mm_reset, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  int grant_q[$];

  // engine stub configuration
  int eng_lat = 5;
  int eng_hold_cfg = 0;
  bit eng_never = 1'b0;
  int eng_cnt, eng_hold;
  logic [MAT_W-1:0] eng_pend;

  always #5 clk = ~clk;

  matmul_job_arbiter #(.NUM_REQ(NUM_REQ), .MAT_W(MAT_W), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .rsp_err(rsp_err), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c),
    .mm_done(mm_done), .mm_reset(mm_reset), .busy(busy)
  );

  function automatic logic [MAT_W-1:0] mat_mul(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    logic [MAT_W-1:0] c;
    logic [7:0] acc, ea, eb;
    c = '0;
    for (int r = 0; r < 10; r++)
      for (int col = 0; col < 10; col++) begin
        acc = 8'h00;
        for (int k = 0; k < 10; k++) begin
          ea  = a[(r*10+k)*8 +: 8];
          eb  = b[(k*10+col)*8 +: 8];
          acc = acc + 8'(ea * eb);
        end
        c[(r*10+col)*8 +: 8] = acc;
      end
    return c;
  endfunction

  function automatic logic [MAT_W-1:0] fill(input logic [7:0] v);
    logic [MAT_W-1:0] m;
    for (int e = 0; e < 100; e++) m[e*8 +: 8] = v;
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] identity();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int r = 0; r < 10; r++) m[(r*11)*8 +: 8] = 8'h01;
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] ramp();
    logic [MAT_W-1:0] m;
    for (int e = 0; e < 100; e++) m[e*8 +: 8] = 8'(e);
    return m;
  endfunction

  // Engine stub: done level held from job end until the next start (optionally longer)
  always @(posedge clk) begin
    if (reset || mm_reset) begin
      mm_done  <= 1'b0;
      mm_c     <= '0;
      eng_cnt  <= 0;
      eng_hold <= 0;
    end else if (mm_start) begin
      eng_pend <= mat_mul(mm_a, mm_b);
      eng_cnt  <= eng_never ? 0 : eng_lat;
      eng_hold <= eng_hold_cfg;
      if (eng_hold_cfg == 0) mm_done <= 1'b0;
    end else begin
      if (eng_hold == 1) mm_done <= 1'b0;
      if (eng_hold != 0) eng_hold <= eng_hold - 1;
      if (eng_cnt == 1) begin
        mm_done <= 1'b1;
        mm_c    <= eng_pend;
      end
      if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
    end
  end

  // Monitor handshakes and start pulses mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (mm_start) start_cnt++;
      for (int i = 0; i < int'(NUM_REQ); i++)
        if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    req_a[i*MAT_W +: MAT_W] = a;
    req_b[i*MAT_W +: MAT_W] = b;
  endtask

  task automatic apply_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output int idx, output bit ok);
    ok = 1'b0; idx = -1;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (|req_ready) begin
        ok = 1'b1;
        for (int i = 0; i < int'(NUM_REQ); i++) if (req_ready[i]) idx = i;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int max, output int idx, output int cyc, output bit ok);
    ok = 1'b0; idx = -1; cyc = 0;
    for (int n = 0; n < max; n++) begin
      tick();
      cyc++;
      if (|rsp_valid) begin
        ok = 1'b1;
        for (int i = 0; i < int'(NUM_REQ); i++) if (rsp_valid[i]) idx = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    tick(); tick(); tick();
    n_checks++; if ({req_ready, rsp_valid, rsp_err, mm_start, mm_reset, busy} !== '0)
      $display("FAIL rst_ctrl got %b exp 0", {req_ready, rsp_valid, rsp_err, mm_start, mm_reset, busy}); else n_pass++;
    n_checks++; if (rsp_c !== '0) $display("FAIL rst_rsp_c got %h exp 0", rsp_c); else n_pass++;
    n_checks++; if (mm_a !== '0 || mm_b !== '0) $display("FAIL rst_mm_ab got %h/%h exp 0", mm_a, mm_b); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_idle_busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    int gi, ri, cyc, s0, g0;
    bit ok;
    set_op(0, fill(8'h01), fill(8'h01));
    rsp_ready = '0;
    s0 = start_cnt; g0 = grant_q.size();
    req_valid = 4'b0001;
    wait_grant(gi, ok);
    n_checks++; if (!ok || gi != 0) $display("FAIL t1_grant got %0d exp 0", gi); else n_pass++;
    tick();
    n_checks++; if (mm_start !== 1'b1) $display("FAIL t1_start got %b exp 1", mm_start); else n_pass++;
    req_valid = '0;
    wait_rsp(100, ri, cyc, ok);
    n_checks++; if (!ok || rsp_valid !== 4'b0001) $display("FAIL t1_rsp_valid got %b exp 0001", rsp_valid); else n_pass++;
    n_checks++; if (cyc != 7) $display("FAIL t1_latency got %0d exp 7", cyc); else n_pass++;
    n_checks++; if (rsp_c !== fill(8'h0A)) $display("FAIL t1_rsp_c got %h exp %h", rsp_c, fill(8'h0A)); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL t1_rsp_err got %b exp 0", rsp_err); else n_pass++;
    n_checks++; if (start_cnt - s0 != 1 || grant_q.size() - g0 != 1)
      $display("FAIL t1_pulses got start %0d grant %0d exp 1 1", start_cnt - s0, grant_q.size() - g0); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 4'b0001) $display("FAIL t1_hold got %b exp 0001", rsp_valid); else n_pass++;
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    n_checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0)
      $display("FAIL t1_consume got %b busy %b exp 0000 0", rsp_valid, busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int ri, cyc, s0, g0;
    bit ok;
    apply_reset();
    for (int i = 0; i < int'(NUM_REQ); i++) set_op(i, fill(8'(i + 1)), fill(8'h01));
    s0 = start_cnt; g0 = grant_q.size();
    rsp_ready = 4'b1111;
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_rsp(100, ri, cyc, ok);
      n_checks++; if (!ok || ri != exp_order[j]) $display("FAIL t2_rsp_idx%0d got %0d exp %0d", j, ri, exp_order[j]); else n_pass++;
      n_checks++; if (rsp_c !== fill(8'(10 * (exp_order[j] + 1))))
        $display("FAIL t2_rsp_c%0d got %h exp %h", j, rsp_c, fill(8'(10 * (exp_order[j] + 1)))); else n_pass++;
    end
    req_valid = '0;
    tick(); tick();
    n_checks++; if (grant_q.size() - g0 != 5) $display("FAIL t2_grant_cnt got %0d exp 5", grant_q.size() - g0); else n_pass++;
    for (int j = 0; j < 5 && g0 + j < grant_q.size(); j++) begin
      n_checks++; if (grant_q[g0 + j] != exp_order[j])
        $display("FAIL t2_grant%0d got %0d exp %0d", j, grant_q[g0 + j], exp_order[j]); else n_pass++;
    end
    n_checks++; if (start_cnt - s0 != 5) $display("FAIL t2_starts got %0d exp 5", start_cnt - s0); else n_pass++;
    rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    int gi, ri, cyc, s0, g0;
    bit ok, stable;
    set_op(0, fill(8'h02), fill(8'h01));
    set_op(1, fill(8'h03), fill(8'h01));
    rsp_ready = 4'b0010;
    req_valid = 4'b0001;
    wait_grant(gi, ok);
    n_checks++; if (!ok || gi != 0) $display("FAIL t3_grant0 got %0d exp 0", gi); else n_pass++;
    tick();
    req_valid = 4'b0010;
    wait_rsp(100, ri, cyc, ok);
    n_checks++; if (!ok || ri != 0) $display("FAIL t3_rsp_idx got %0d exp 0", ri); else n_pass++;
    s0 = start_cnt; g0 = grant_q.size();
    stable = 1'b1;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (rsp_valid !== 4'b0001 || rsp_c !== fill(8'h14)) stable = 1'b0;
    end
    n_checks++; if (!stable) $display("FAIL t3_stall_hold got %b %h exp 0001 %h", rsp_valid, rsp_c, fill(8'h14)); else n_pass++;
    n_checks++; if (start_cnt != s0 || grant_q.size() != g0)
      $display("FAIL t3_stall_idle got start %0d grant %0d exp 0 0", start_cnt - s0, grant_q.size() - g0); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL t3_busy got %b exp 1", busy); else n_pass++;
    rsp_ready = 4'b0001;
    tick();
    n_checks++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0000)
      $display("FAIL t3_release got %b/%b exp 0000/0000", rsp_valid, req_ready); else n_pass++;
    rsp_ready = 4'b0010;
    tick();
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL t3_next_grant got %b exp 0010", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    wait_rsp(100, ri, cyc, ok);
    n_checks++; if (!ok || ri != 1 || rsp_c !== fill(8'h1E))
      $display("FAIL t3_job1 got %0d %h exp 1 %h", ri, rsp_c, fill(8'h1E)); else n_pass++;
    tick();
    rsp_ready = '0;
  endtask

  task automatic test_stale_done();
    int gi, ri, cyc;
    bit ok;
    eng_hold_cfg = 3; eng_lat = 8;
    set_op(2, identity(), ramp());
    rsp_ready = 4'b0100;
    req_valid = 4'b0100;
    wait_grant(gi, ok);
    n_checks++; if (!ok || gi != 2) $display("FAIL t4_grant got %0d exp 2", gi); else n_pass++;
    tick();
    req_valid = '0;
    wait_rsp(100, ri, cyc, ok);
    n_checks++; if (!ok || ri != 2 || cyc != 10) $display("FAIL t4_latency got idx %0d cyc %0d exp 2 10", ri, cyc); else n_pass++;
    n_checks++; if (rsp_c !== ramp()) $display("FAIL t4_rsp_c got %h exp %h", rsp_c, ramp()); else n_pass++;
    n_checks++; if (mm_a !== identity() || mm_b !== ramp()) $display("FAIL t4_operands_held got %h exp %h", mm_a, identity()); else n_pass++;
    tick();
    rsp_ready = '0;
    eng_hold_cfg = 0; eng_lat = 5;
  endtask

  task automatic test_reset_mid();
    int gi, ri, cyc;
    bit ok;
    set_op(0, fill(8'h02), fill(8'h01));
    set_op(1, fill(8'h01), fill(8'h01));
    rsp_ready = '0;
    req_valid = 4'b0010;
    wait_grant(gi, ok);
    n_checks++; if (!ok || gi != 1) $display("FAIL t5_grant got %0d exp 1", gi); else n_pass++;
    tick();
    req_valid = '0;
    tick(); tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL t5_busy got %b exp 1", busy); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if ({req_ready, rsp_valid, rsp_err, mm_start, mm_reset, busy} !== '0)
      $display("FAIL t5_ctrl_clear got %b exp 0", {req_ready, rsp_valid, rsp_err, mm_start, mm_reset, busy}); else n_pass++;
    n_checks++; if (rsp_c !== '0 || mm_a !== '0 || mm_b !== '0)
      $display("FAIL t5_data_clear got %h exp 0", mm_a); else n_pass++;
    reset = 1'b0;
    rsp_ready = 4'b1111;
    req_valid = 4'b1111;
    wait_grant(gi, ok);
    n_checks++; if (!ok || gi != 0) $display("FAIL t5_rr_ptr got %0d exp 0", gi); else n_pass++;
    tick();
    req_valid = '0;
    wait_rsp(100, ri, cyc, ok);
    n_checks++; if (!ok || ri != 0 || rsp_c !== fill(8'h14))
      $display("FAIL t5_recover got %0d %h exp 0 %h", ri, rsp_c, fill(8'h14)); else n_pass++;
    tick();
    rsp_ready = '0;
  endtask

`ifdef MATMUL_TIMEOUT_EN
  task automatic test_timeout();
    int gi, ri, cyc;
    bit ok;
    eng_never = 1'b1;
    set_op(3, fill(8'h01), fill(8'h01));
    rsp_ready = '0;
    req_valid = 4'b1000;
    wait_grant(gi, ok);
    tick();
    req_valid = '0;
    wait_rsp(200, ri, cyc, ok);
    n_checks++; if (!ok || ri != 3 || cyc != 65) $display("FAIL t6_timeout got idx %0d cyc %0d exp 3 65", ri, cyc); else n_pass++;
    n_checks++; if (mm_reset !== 1'b1 || rsp_err !== 1'b1 || rsp_c !== '0)
      $display("FAIL t6_abort got rst %b err %b exp 1 1", mm_reset, rsp_err); else n_pass++;
    tick();
    n_checks++; if (mm_reset !== 1'b0 || rsp_err !== 1'b1) $display("FAIL t6_pulse got rst %b err %b exp 0 1", mm_reset, rsp_err); else n_pass++;
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = '0;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL t6_err_clear got %b exp 0", rsp_err); else n_pass++;
    eng_never = 1'b0;
    req_valid = 4'b1000;
    wait_grant(gi, ok);
    tick();
    req_valid = '0;
    wait_rsp(100, ri, cyc, ok);
    n_checks++; if (!ok || rsp_err !== 1'b0 || rsp_c !== fill(8'h0A))
      $display("FAIL t6_next_job got err %b %h exp 0 %h", rsp_err, rsp_c, fill(8'h0A)); else n_pass++;
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stale_done();
    test_reset_mid();
`ifdef MATMUL_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
